cache_controller: RTL and testbench
===================================

# cache_controller

Sequences every data-memory access from the MEM stage through the 2-way data cache and the SRAM controller. Read hits complete in the request cycle. Read misses fetch a 64-bit word pair from SRAM, fill the cache and return the requested word. Writes are write-through / no-write-allocate: a hit line is invalidated and the word is written to SRAM. The block drives `ready`, which the pipeline uses as its freeze signal.

## Interface
- No parameters. Fixed values: data base address 1024; cache address 17 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `address`  in  32  byte address from the MEM stage; word-aligned and ≥1024.
- `wdata`  in  32  store data.
- `MEM_R_EN`  in  1  load request.
- `MEM_W_EN`  in  1  store request.
- `rdata`  out  32  load result; valid when `ready`=1 and `MEM_R_EN`=1.
- `ready`  out  1  access complete / no access pending (combinational).
- `cache_address`  out  17  `((address-1024)>>2)[16:0]`; bit 0 is the word offset, bits [6:1] the index, bits [16:7] the tag.
- `cache_write_data`  out  64  equals `sram_rdata`.
- `cache_read_en`  out  1  LRU-update strobe to the cache.
- `cache_write_en`  out  1  fill strobe to the cache.
- `cache_invoke_set_en`  out  1  invalidate-on-hit strobe to the cache.
- `cache_read_data`  in  32  cache data for the current address (combinational).
- `cache_hit`  in  1  cache hit for the current address (combinational).
- `sram_address`  out  32  SRAM controller address.
- `sram_wdata`  out  32  equals `wdata`.
- `sram_write`  out  1  SRAM write request; held until `sram_ready`.
- `sram_read`  out  1  SRAM read request; held until `sram_ready`.
- `sram_rdata`  in  64  pair data: {word at offset 1, word at offset 0}.
- `sram_ready`  in  1  one-cycle completion pulse from the SRAM controller.
- `hit_count`  out  16  saturating count of read hits.
- `miss_count`  out  16  saturating count of read misses.

## Operation
- FSM states: IDLE, READ_MISS, WRITE.
- Address mapping:
  - `sram_address` = {address[31:3],3'b000} in READ_MISS.
  - `sram_address` = `address` in WRITE and IDLE.
- Request precedence: if `MEM_W_EN` and `MEM_R_EN` are both high, the store is served and the load is ignored.
- IDLE, no request: `ready`=1; all strobes 0.
- IDLE, `MEM_R_EN`, `cache_hit`=1:
  - `ready`=1, `rdata`=`cache_read_data`, `cache_read_en`=1.
  - `hit_count`+1.
  - Stay in IDLE.
- IDLE, `MEM_R_EN`, `cache_hit`=0:
  - `ready`=0, `sram_read`=1.
  - `miss_count`+1 (counted once per miss).
  - Next state READ_MISS.
- READ_MISS:
  - `sram_read`=1, `ready`=0 until `sram_ready`.
  - In the `sram_ready` cycle: `cache_write_en`=1, `rdata`=`cache_address[0]` ? `sram_rdata[63:32]` : `sram_rdata[31:0]`, `ready`=1, `sram_read`=0 from this cycle.
  - Next state IDLE.
- IDLE, `MEM_W_EN`:
  - `cache_invoke_set_en`=1 for exactly this cycle; the cache invalidates the line only on a hit.
  - `sram_write`=1, `ready`=0.
  - Next state WRITE.
- WRITE:
  - `sram_write`=1 until `sram_ready`.
  - In the `sram_ready` cycle: `ready`=1, `sram_write`=0.
  - Next state IDLE.
- The pipeline holds `address`, `wdata` and the enables stable while `ready`=0.
- `sram_ready` is ignored in IDLE.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset values: state IDLE; `hit_count`=`miss_count`=0; `ready`=1; all strobes 0; `rdata`=0 when not returning data.
- Reset during READ_MISS or WRITE:
  - FSM returns to IDLE at that edge; `sram_read`/`sram_write` drop the next cycle.
  - No cache fill occurs.
  - A partially issued SRAM write is the SRAM controller's concern.
- Latency:
  - Read hit: 0 extra cycles (same-cycle `ready`).
  - Read miss: 1 + N cycles, where N is the number of cycles until `sram_ready` (N≥1).
  - Write: 1 + N cycles.
- The cache fill and the LRU update take effect at the rising edge that ends the `ready`=1 cycle.
- A new request may be accepted in the cycle immediately after completion; there are no bubbles.

## Test plan
- Reset, then a read of `address`=1024 (miss). SRAM returns `sram_rdata`=64'h00000022_00000011 after 3 cycles.
  - Required: `ready` low for 4 cycles, `sram_address`=1024, `rdata`=32'h11, `cache_write_en` pulses once, `miss_count`=1.
- Next, a read of 1028 (same line, offset 1, now a hit).
  - Required: `ready`=1 in the same cycle, `rdata`=32'h22, `cache_read_en`=1, `hit_count`=1.
- Write 1024 ← 32'hAB with `cache_hit`=1.
  - Required: `cache_invoke_set_en` is a single-cycle pulse, `sram_write` held until `sram_ready`, `sram_address`=1024, `sram_wdata`=32'hAB.
  - A following read of 1024 is a miss and refetches.
- Read of 1036 (index 1, offset 1, miss).
  - Required: `cache_address`=17'd3, `sram_address`=1032, `rdata`=`sram_rdata[63:32]`.
- Assert `rst` in the second cycle of READ_MISS.
  - Required: next state IDLE, `ready`=1, `sram_read`=0 the following cycle, no `cache_write_en`, counters 0.
- Preload `hit_count`=16'hFFFE, then issue 3 read hits.
  - Required: `hit_count` saturates at 16'hFFFF.
- Drive `MEM_R_EN` and `MEM_W_EN` high together.
  - Required: the write path is taken and `sram_read` is never asserted.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: sequences MEM-stage loads/stores through a 2-way data
// cache and the SRAM controller. Read hits finish in the request cycle,
// read misses fetch a 64-bit word pair and fill the cache, and stores are
// write-through / no-write-allocate (a hit line is invalidated).
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [16:0] cache_address,
    output logic [63:0] cache_write_data,
    output logic        cache_read_en,
    output logic        cache_write_en,
    output logic        cache_invoke_set_en,
    input  logic [31:0] cache_read_data,
    input  logic        cache_hit,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_write,
    output logic        sram_read,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    state_t      state_q, state_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic        hit_inc, miss_inc;

    // Data region starts at byte 1024; since 1024 is word-aligned the
    // subtraction can be done on the word address directly.
    assign cache_address    = address[18:2] - 17'd256;
    assign cache_write_data = sram_rdata;
    assign sram_wdata       = wdata;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

    // Next-state and per-cycle strobe decode; stores win over loads.
    always_comb begin
        state_d             = state_q;
        ready               = 1'b1;
        rdata               = 32'd0;
        cache_read_en       = 1'b0;
        cache_write_en      = 1'b0;
        cache_invoke_set_en = 1'b0;
        sram_address        = address;
        sram_read           = 1'b0;
        sram_write          = 1'b0;
        hit_inc             = 1'b0;
        miss_inc            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    cache_invoke_set_en = 1'b1;
                    sram_write          = 1'b1;
                    ready               = 1'b0;
                    state_d             = WRITE;
                end else if (MEM_R_EN) begin
                    if (cache_hit) begin
                        rdata         = cache_read_data;
                        cache_read_en = 1'b1;
                        hit_inc       = 1'b1;
                    end else begin
                        ready     = 1'b0;
                        sram_read = 1'b1;
                        miss_inc  = 1'b1;
                        state_d   = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                // Fetch the aligned word pair that holds the requested word.
                sram_address = {address[31:3], 3'b000};
                if (sram_ready) begin
                    cache_write_en = 1'b1;
                    rdata          = cache_address[0] ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_d        = IDLE;
                end else begin
                    sram_read = 1'b1;
                    ready     = 1'b0;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    state_d = IDLE;
                end else begin
                    sram_write = 1'b1;
                    ready      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating hit/miss statistics.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_inc && hit_count_q != 16'hFFFF)
            hit_count_d = hit_count_q + 16'd1;
        if (miss_inc && miss_count_q != 16'hFFFF)
            miss_count_d = miss_count_q + 16'd1;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Table-driven bench for cache_controller: one record per clock cycle with
// the inputs to drive and the outputs expected in that cycle, followed by a
// hand-written hit-counter saturation sequence.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [16:0] cache_address;
    logic [63:0] cache_write_data;
    logic        cache_read_en, cache_write_en, cache_invoke_set_en;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic [31:0] sram_address, sram_wdata;
    logic        sram_write, sram_read;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [15:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_write_data(cache_write_data),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_invoke_set_en(cache_invoke_set_en), .cache_read_data(cache_read_data),
        .cache_hit(cache_hit), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_write(sram_write), .sram_read(sram_read), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        r, w, hit;
        logic [31:0] crd;
        logic        srdy;
        logic [63:0] srd;
        logic        e_ready;
        logic [31:0] e_rdata;
        logic [16:0] e_caddr;
        logic [31:0] e_saddr;
        logic [4:0]  e_str;   // {sram_read, sram_write, cache_read_en, cache_write_en, cache_invoke_set_en}
        logic [15:0] e_hc, e_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, input logic [31:0] addr, input logic [31:0] wd,
        input logic r, input logic w, input logic hit, input logic [31:0] crd,
        input logic srdy, input logic [63:0] srd,
        input logic e_ready, input logic [31:0] e_rdata, input logic [16:0] e_caddr,
        input logic [31:0] e_saddr, input logic [4:0] e_str,
        input logic [15:0] e_hc, input logic [15:0] e_mc);
        vec_t v;
        v.rst = rst_i; v.addr = addr; v.wd = wd; v.r = r; v.w = w; v.hit = hit;
        v.crd = crd; v.srdy = srdy; v.srd = srd; v.e_ready = e_ready;
        v.e_rdata = e_rdata; v.e_caddr = e_caddr; v.e_saddr = e_saddr;
        v.e_str = e_str; v.e_hc = e_hc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; address = v.addr; wdata = v.wd; MEM_R_EN = v.r; MEM_W_EN = v.w;
        cache_hit = v.hit; cache_read_data = v.crd; sram_ready = v.srdy; sram_rdata = v.srd;
    endtask

    localparam logic [63:0] P1 = 64'h00000022_00000011;
    localparam logic [63:0] P2 = 64'h00000022_000000AB;
    localparam logic [63:0] P3 = 64'hDEAD0002_BEEF0001;

    initial begin
        // strobe codes: SR=10000 SW=01000 CRE=00100 CWE=00010 CINV=00001
        //           rst addr  wd     r  w  hit crd     srdy srd  rdy rdata          caddr saddr str       hc mc
        vecs.push_back(mk(0, 1024, 0,     0, 0, 0, 0,      0, 0,  1, 0,             0, 1024, 5'b00000, 0, 0)); // 0 post-reset idle
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 0, 0)); // 1 read miss request
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 0, 1)); // 2 READ_MISS
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 0, 1)); // 3
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 0, 1)); // 4
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      1, P1, 1, 32'h11,        0, 1024, 5'b00010, 0, 1)); // 5 fill, offset 0
        vecs.push_back(mk(0, 1028, 0,     1, 0, 1, 32'h22, 0, 0,  1, 32'h22,        1, 1028, 5'b00100, 0, 1)); // 6 read hit
        vecs.push_back(mk(0, 1028, 0,     0, 0, 0, 0,      0, 0,  1, 0,             1, 1028, 5'b00000, 1, 1)); // 7 idle
        vecs.push_back(mk(0, 1024, 32'hAB, 0, 1, 1, 0,     0, 0,  0, 0,             0, 1024, 5'b01001, 1, 1)); // 8 write, invalidate
        vecs.push_back(mk(0, 1024, 32'hAB, 0, 1, 1, 0,     0, 0,  0, 0,             0, 1024, 5'b01000, 1, 1)); // 9 WRITE wait
        vecs.push_back(mk(0, 1024, 32'hAB, 0, 1, 1, 0,     1, 0,  1, 0,             0, 1024, 5'b00000, 1, 1)); // 10 WRITE done
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 1, 1)); // 11 refetch miss
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      1, P2, 1, 32'hAB,        0, 1024, 5'b00010, 1, 2)); // 12 N=1 fill
        vecs.push_back(mk(0, 1036, 0,     1, 0, 0, 0,      0, 0,  0, 0,             3, 1036, 5'b10000, 1, 2)); // 13 miss idx1 off1
        vecs.push_back(mk(0, 1036, 0,     1, 0, 0, 0,      0, 0,  0, 0,             3, 1032, 5'b10000, 1, 3)); // 14 aligned fetch
        vecs.push_back(mk(0, 1036, 0,     1, 0, 0, 0,      1, P3, 1, 32'hDEAD0002,  3, 1032, 5'b00010, 1, 3)); // 15 upper word
        vecs.push_back(mk(0, 1040, 32'h55, 1, 1, 0, 0,     0, 0,  0, 0,             4, 1040, 5'b01001, 1, 3)); // 16 R+W: write wins
        vecs.push_back(mk(0, 1040, 32'h55, 1, 1, 0, 0,     0, 0,  0, 0,             4, 1040, 5'b01000, 1, 3)); // 17
        vecs.push_back(mk(0, 1040, 32'h55, 1, 1, 0, 0,     1, 0,  1, 0,             4, 1040, 5'b00000, 1, 3)); // 18
        vecs.push_back(mk(0, 1040, 0,     0, 0, 0, 0,      1, P1, 1, 0,             4, 1040, 5'b00000, 1, 3)); // 19 sram_ready ignored in IDLE
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 1, 3)); // 20 miss
        vecs.push_back(mk(0, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 1, 4)); // 21 READ_MISS c1
        vecs.push_back(mk(1, 1024, 0,     1, 0, 0, 0,      0, 0,  0, 0,             0, 1024, 5'b10000, 1, 4)); // 22 reset in c2
        vecs.push_back(mk(0, 1024, 0,     0, 0, 0, 0,      0, 0,  1, 0,             0, 1024, 5'b00000, 0, 0)); // 23 back to IDLE

        // Initial reset
        drive(mk(1, 1024, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("ready",          i, 64'(ready),            64'(vecs[i].e_ready));
            chk("rdata",          i, 64'(rdata),            64'(vecs[i].e_rdata));
            chk("cache_address",  i, 64'(cache_address),    64'(vecs[i].e_caddr));
            chk("sram_address",   i, 64'(sram_address),     64'(vecs[i].e_saddr));
            chk("strobes",        i, 64'({sram_read, sram_write, cache_read_en, cache_write_en, cache_invoke_set_en}),
                                     64'(vecs[i].e_str));
            chk("hit_count",      i, 64'(hit_count),        64'(vecs[i].e_hc));
            chk("miss_count",     i, 64'(miss_count),       64'(vecs[i].e_mc));
            chk("sram_wdata",     i, 64'(sram_wdata),       64'(vecs[i].wd));
            chk("cache_wr_data",  i, cache_write_data,      vecs[i].srd);
            @(posedge clk);
            #1;
        end

        // Hit-counter saturation: run hits back to back up to 16'hFFFE,
        // then three more must stop at 16'hFFFF.
        drive(mk(0, 1028, 0, 1, 0, 1, 32'h5A5A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("sat_ready", 100, 64'(ready), 64'd1);
        chk("sat_rdata", 100, 64'(rdata), 64'h5A5A);
        repeat (65534) @(posedge clk);
        #1;
        chk("hit_count_fffe", 101, 64'(hit_count), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("hit_count_sat", 102, 64'(hit_count), 64'hFFFF);
        chk("miss_count_sat", 102, 64'(miss_count), 64'd0);
        chk("sat_ready_end", 102, 64'(ready), 64'd1);

        MEM_R_EN = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
